// File: rtl/store_buffer.sv
// Store buffer between the ROB and the D-cache: holds executed stores, drains committed ones in order
// and forwards data to younger loads. Define STORE_BUFFER_FWD_EN to build the load-forwarding path.
module store_buffer #(
   parameter int SB_SIZE   = 4,
   parameter int ROB_IDX_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_alloc,
   input  logic [ROB_IDX_W-1:0] in_rob_idx,
   input  logic [31:0]          in_addr,
   input  logic [31:0]          in_data,
   input  logic [1:0]           in_size,
   input  logic                 in_commit,
   input  logic [ROB_IDX_W-1:0] in_commit_rob_idx,
   input  logic                 in_flush,
   input  logic [31:0]          in_ld_addr,
   input  logic [1:0]           in_ld_size,
   output logic                 out_fwd_hit,
   output logic [31:0]          out_fwd_data,
   output logic                 out_fwd_stall,
   output logic                 out_cache_req,
   output logic [31:0]          out_cache_addr,
   output logic [31:0]          out_cache_data,
   output logic [1:0]           out_cache_size,
   input  logic                 in_cache_ack,
   output logic                 out_full,
   output logic                 out_empty
);

   localparam int PTR_W = $clog2(SB_SIZE);
   localparam int CNT_W = $clog2(SB_SIZE + 1);

   typedef enum logic {IDLE, REQ} drain_state_t;

   drain_state_t state, state_nxt;

   logic [SB_SIZE-1:0]   ent_valid, ent_committed, commit_hit;
   logic [SB_SIZE-1:0]   valid_nxt, comm_nxt;
   logic [ROB_IDX_W-1:0] ent_rob_idx [SB_SIZE];
   logic [31:0]          ent_addr    [SB_SIZE];
   logic [31:0]          ent_data    [SB_SIZE];
   logic [1:0]           ent_size    [SB_SIZE];
   logic [3:0]           ent_mask    [SB_SIZE];
   logic [PTR_W-1:0]     head, tail, head_nxt, tail_nxt;
   logic [CNT_W-1:0]     count, count_nxt, n_comm;
   logic                 pop, do_alloc;
   logic [3:0]           ld_mask;

   function automatic logic [3:0] byte_mask(input logic [1:0] a, input logic [1:0] sz);
      case (sz)
         2'b00:   return 4'b0001 << a;
         2'b01:   return 4'b0011 << a;
         default: return 4'b1111;
      endcase
   endfunction

   // SB_SIZE need not be a power of two, so pointer arithmetic wraps explicitly
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] n);
      logic [CNT_W:0] s;
      s = {{(CNT_W + 1 - PTR_W){1'b0}}, p} + {1'b0, n};
      if (s >= (CNT_W + 1)'(SB_SIZE)) s = s - (CNT_W + 1)'(SB_SIZE);
      return s[PTR_W-1:0];
   endfunction

   assign pop      = (state == REQ) && in_cache_ack;
   assign do_alloc = in_alloc && !out_full && !in_flush;
   assign out_full  = (count == CNT_W'(SB_SIZE));
   assign out_empty = (count == '0);
   assign ld_mask   = byte_mask(in_ld_addr[1:0], in_ld_size);

   always_comb begin
      commit_hit = '0;
      n_comm     = '0;
      for (int i = 0; i < SB_SIZE; i++) begin
         commit_hit[i] = in_commit && ent_valid[i] && !ent_committed[i] &&
                         (ent_rob_idx[i] == in_commit_rob_idx);
         if (ent_valid[i] && (ent_committed[i] || commit_hit[i])) n_comm = n_comm + CNT_W'(1);
      end
   end

   // Commit lands before flush; committed entries form a run from head, so tail restarts after them
   always_comb begin
      valid_nxt = ent_valid;
      comm_nxt  = ent_committed | commit_hit;
      head_nxt  = head;
      tail_nxt  = tail;
      count_nxt = count;
      if (pop) begin
         valid_nxt[head] = 1'b0;
         comm_nxt[head]  = 1'b0;
         head_nxt        = ptr_add(head, CNT_W'(1));
      end
      if (in_flush) begin
         valid_nxt = valid_nxt & comm_nxt;
         tail_nxt  = ptr_add(head, n_comm);
         count_nxt = n_comm - CNT_W'(pop);
      end else begin
         if (do_alloc) begin
            valid_nxt[tail] = 1'b1;
            comm_nxt[tail]  = 1'b0;
            tail_nxt        = ptr_add(tail, CNT_W'(1));
         end
         count_nxt = count + CNT_W'(do_alloc) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         ent_valid     <= '0;
         ent_committed <= '0;
      end else begin
         head          <= head_nxt;
         tail          <= tail_nxt;
         count         <= count_nxt;
         ent_valid     <= valid_nxt;
         ent_committed <= comm_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_alloc) begin
         ent_rob_idx[tail] <= in_rob_idx;
         ent_addr[tail]    <= in_addr;
         ent_data[tail]    <= in_data;
         ent_size[tail]    <= in_size;
         ent_mask[tail]    <= byte_mask(in_addr[1:0], in_size);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // A commit of the head store this cycle starts the drain without waiting for the committed bit
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (ent_valid[head] && (ent_committed[head] || commit_hit[head])) state_nxt = REQ;
         REQ:  if (in_cache_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_cache_req  = (state == REQ);
      out_cache_addr = ent_addr[head];
      out_cache_data = ent_data[head];
      out_cache_size = ent_size[head];
   end

`ifdef STORE_BUFFER_FWD_EN
   logic             fwd_found;
   logic [PTR_W-1:0] fwd_sel, scan_idx;
   logic [31:0]      fwd_lane, fwd_shifted, fwd_keep;

   // Walk oldest to youngest so the last overlapping entry seen is the youngest
   always_comb begin
      fwd_found = 1'b0;
      fwd_sel   = '0;
      scan_idx  = '0;
      for (int k = 0; k < SB_SIZE; k++) begin
         scan_idx = ptr_add(head, CNT_W'(k));
         if (ent_valid[scan_idx] && (ent_addr[scan_idx][31:2] == in_ld_addr[31:2]) &&
             |(ent_mask[scan_idx] & ld_mask)) begin
            fwd_found = 1'b1;
            fwd_sel   = scan_idx;
         end
      end
      case (in_ld_size)
         2'b00:   fwd_keep = 32'h0000_00FF;
         2'b01:   fwd_keep = 32'h0000_FFFF;
         default: fwd_keep = 32'hFFFF_FFFF;
      endcase
      fwd_lane      = ent_data[fwd_sel] << {ent_addr[fwd_sel][1:0], 3'b000};
      fwd_shifted   = fwd_lane >> {in_ld_addr[1:0], 3'b000};
      out_fwd_hit   = fwd_found && ((ld_mask & ~ent_mask[fwd_sel]) == 4'b0000);
      out_fwd_stall = fwd_found && !out_fwd_hit;
      out_fwd_data  = out_fwd_hit ? (fwd_shifted & fwd_keep) : 32'h0;
   end
`else
   always_comb begin
      out_fwd_hit   = 1'b0;
      out_fwd_data  = 32'h0;
      out_fwd_stall = 1'b0;
      for (int i = 0; i < SB_SIZE; i++) begin
         if (ent_valid[i] && (ent_addr[i][31:2] == in_ld_addr[31:2]) && |(ent_mask[i] & ld_mask))
            out_fwd_stall = 1'b1;
      end
   end
`endif

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the reorder buffer and upstream of the data cache.
- Holds stores from execute (address and data known) until the ROB retires them. It then drains committed stores to the D-cache in program order through a req/ack handshake.
- Discards uncommitted stores on a ROB exception flush.
- Forwards store data to younger loads.

Parameters:
- SB_SIZE, 4, number of entries (2..8).
- ROB_IDX_W, 4, width of ROB index tags; matches the ROB alloc index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_alloc  in  1  execute presents a store this cycle.
- in_rob_idx  in  ROB_IDX_W  ROB tag of the presented store.
- in_addr  in  32  store byte address.
- in_data  in  32  store data, right-aligned.
- in_size  in  2  size code: 00 byte, 01 half, 10 word.
- in_commit  in  1  ROB retires a store this cycle.
- in_commit_rob_idx  in  ROB_IDX_W  tag of the retiring store.
- in_flush  in  1  ROB exception flush.
- in_ld_addr  in  32  load address for the forwarding lookup.
- in_ld_size  in  2  load size code.
- out_fwd_hit  out  1  load fully covered; data valid.
- out_fwd_data  out  32  forwarded data, right-aligned, not sign-extended.
- out_fwd_stall  out  1  partial overlap; load must retry.
- out_cache_req  out  1  drain request to the D-cache.
- out_cache_addr  out  32  drain address.
- out_cache_data  out  32  drain data.
- out_cache_size  out  2  drain size.
- in_cache_ack  in  1  cache accepts the request this cycle.
- out_full  out  1  count == SB_SIZE.
- out_empty  out  1  count == 0.

Behaviour:
- Storage is a circular FIFO with head, tail and count registers. Each entry holds valid, committed, rob_idx, addr, data, size and a 4-bit byte mask.
- Byte mask is built from addr[1:0] and size: byte 0001<<a, half 0011<<a, word 1111.
- Misaligned stores are not checked here; execute guarantees alignment.
- Reset (reset=0, asynchronous):
  - head, tail and count clear to 0; all valid and committed bits clear.
  - Drain FSM returns to IDLE; out_cache_req=0.
  - out_full=0, out_empty=1.
- Reset mid-drain aborts the request immediately, with no ack required.
- Alloc: on in_alloc && !out_full && !in_flush, write the entry at tail with valid=1, committed=0, then tail++ (wrapping at SB_SIZE) and count++.
  - Alloc while full is dropped, even if a pop occurs the same cycle.
  - The new entry is visible to forwarding from the next cycle.
- Commit: on in_commit, set committed on the valid, uncommitted entry whose rob_idx equals in_commit_rob_idx.
  - No match means no effect.
  - Committed entries are always a contiguous run starting at head.
- Flush: on in_flush, clear every valid, uncommitted entry.
  - tail is set to head + number of committed entries (mod SB_SIZE); count is set to that number.
  - Committed entries survive and continue draining.
  - Commit in the same cycle as flush is applied first, so that store survives.
  - Alloc in the same cycle as flush is dropped.
- Drain FSM:
  - IDLE: if the head entry is valid and committed, go to REQ next cycle.
  - REQ: out_cache_req=1, and out_cache_addr/data/size come from the head entry. Hold these stable until in_cache_ack.
  - On ack: invalidate head, head++ (wrapping), count--, go to IDLE.
  - Minimum latency is commit at cycle N, req high at N+1.
  - Back-to-back drains occur at most every 2 cycles.
  - in_flush has no effect on REQ.
  - in_cache_ack while in IDLE is ignored.
- Count rules when alloc and pop occur in the same cycle:
  - Count is unchanged; head and tail both advance.
  - Pop and flush in the same cycle: count = committed entries remaining after the pop.
- Forwarding (combinational):
  - Scan valid entries youngest to oldest (committed or not). Match on addr[31:2] == in_ld_addr[31:2] with overlapping masks.
  - If the youngest overlapping entry's mask covers the load mask: out_fwd_hit=1, and out_fwd_data is that entry's data placed at the store lane, then shifted right by in_ld_addr[1:0]*8, with unloaded bytes zero.
  - If it overlaps without covering: out_fwd_stall=1, out_fwd_hit=0.
  - No overlap: both 0, out_fwd_data=0.
- Outputs out_fwd_hit and out_fwd_stall are never both high.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined: forwarding works as described above.
- Undefined: out_fwd_hit and out_fwd_data are tied to 0, and out_fwd_stall=1 on any byte overlap with any valid entry. The priority scan logic is not built.

Test Plan:
- Reset, then alloc rob 3, addr 0x100, data 0xDEADBEEF, word; then commit rob 3 → out_cache_req rises 1 cycle after commit with addr 0x100 and data 0xDEADBEEF. Ack after 3 cycles → out_empty=1 the cycle after ack; req held stable all 3 cycles.
- Fill 4 entries (rob 1..4) and attempt a 5th alloc → out_full=1 and the 5th is dropped. Commit and drain all → drain order is rob 1,2,3,4, and tail wrap is exercised by 4 more allocs.
- Alloc rob 5,6,7; commit rob 5; assert in_flush in the same cycle as commit of rob 6 → rob 5 and 6 survive and drain, rob 7 is never requested, and count=2 after flush.
- Store byte 0xAB at 0x203, then load byte at 0x203 → hit with data 0x000000AB. Load word at 0x200 → out_fwd_stall=1. Two stores to 0x200, 0x11111111 then 0x22222222, then word load → data 0x22222222.
- Assert reset while in REQ awaiting ack → out_cache_req drops asynchronously, and out_empty=1 after release.
- Build without STORE_BUFFER_FWD_EN; store word at 0x300, then load byte at 0x301 → hit=0, stall=1.
